store_buffer: RTL and testbench

- Posted-write FIFO directly downstream of the store alignment stage in MEM.
- Accepts already-aligned store data and byte-write masks, then drains them in order to the data memory port over a req/ack handshake.
- The pipeline does not wait for slow memory writes.
- Raises a stall when full, and flags loads that hit a pending store's word so the hazard unit can hold the load until the buffer drains.

---
 rtl/store_buffer.sv | 151 +++++++++++++++
 tb/tb_store_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store FIFO between MEM alignment and the data memory port
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [3:0]  StoreMaskM,
  input  logic [31:0] StoreAddrM,
  input  logic [31:0] StoreDataM,
  input  logic        LoadReqM,
  input  logic [31:0] LoadAddrM,
  input  logic        MemAck,
  output logic        StoreStall,
  output logic        LoadHazard,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemMask,
  output logic [31:0] MemWData,
  output logic        Empty
);

  localparam logic [PTR_W:0] FullCount = DEPTH[PTR_W:0];

  logic [29:0]      entryAddr [DEPTH];
  logic [3:0]       entryMask [DEPTH];
  logic [31:0]      entryData [DEPTH];
  logic [DEPTH-1:0] entryValid;

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] nextRdPtr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   nextCount;

  logic [29:0] headAddr;
  logic [3:0]  headMask;
  logic [31:0] headData;
  logic [29:0] nextHeadAddr;
  logic [3:0]  nextHeadMask;
  logic [31:0] nextHeadData;

  logic storeOffered;
  logic enq;
  logic deq;
  logic wordHit;
  logic unusedAddrBits;

  // Byte offsets are irrelevant: storage and hazard matching are word-granular.
  assign unusedAddrBits = ^{StoreAddrM[1:0], LoadAddrM[1:0]};

  // Full is judged on the current count only, so a same-cycle drain never admits a store.
  assign storeOffered = |StoreMaskM;
  assign enq          = storeOffered && (count != FullCount);
  assign deq          = MemReq && MemAck;
  assign StoreStall   = storeOffered && (count == FullCount);
  assign Empty        = (count == '0);
  assign MemReq       = (count != '0);
  assign MemAddr      = {headAddr, 2'b00};
  assign MemMask      = headMask;
  assign MemWData     = headData;

  // Next-state bookkeeping shared by the pointer and head registers.
  always_comb begin
    nextRdPtr = deq ? rdPtr + PTR_W'(1) : rdPtr;
    nextCount = count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
  end

  // Pick the entry that will be at the head after this edge; a store landing in an
  // empty (or just-emptied) buffer bypasses the array so it is presented one cycle later.
  always_comb begin
    nextHeadAddr = headAddr;
    nextHeadMask = 4'b0000;
    nextHeadData = headData;
    if (nextCount != '0) begin
      if (enq && (nextRdPtr == wrPtr)) begin
        nextHeadAddr = StoreAddrM[31:2];
        nextHeadMask = StoreMaskM;
        nextHeadData = StoreDataM;
      end else begin
        nextHeadAddr = entryAddr[nextRdPtr];
        nextHeadMask = entryMask[nextRdPtr];
        nextHeadData = entryData[nextRdPtr];
      end
    end
  end

  // Any valid pending store to the same word blocks the load, whatever its byte mask.
  always_comb begin
    wordHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && (entryAddr[i] == LoadAddrM[31:2])) begin
        wordHit = 1'b1;
      end
    end
  end

  assign LoadHazard = LoadReqM && wordHit;

  // Entry payload; contents of free slots are don't-care so no reset is needed.
  always_ff @(posedge CLK) begin
    if (enq) begin
      entryAddr[wrPtr] <= StoreAddrM[31:2];
      entryMask[wrPtr] <= StoreMaskM;
      entryData[wrPtr] <= StoreDataM;
    end
  end

  // Per-entry valid bits; enqueue and dequeue never target the same slot in one cycle.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      entryValid <= '0;
    end else begin
      if (enq) begin
        entryValid[wrPtr] <= 1'b1;
      end
      if (deq) begin
        entryValid[rdPtr] <= 1'b0;
      end
    end
  end

  // Pointers and occupancy; reset abandons everything including an unacked head.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      rdPtr <= nextRdPtr;
      count <= nextCount;
    end
  end

  // Registered memory-side head; address and data hold their last values when empty.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      headAddr <= '0;
      headMask <= '0;
      headData <= '0;
    end else begin
      headAddr <= nextHeadAddr;
      headMask <= nextHeadMask;
      headData <= nextHeadData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [3:0]  StoreMaskM = '0;
  logic [31:0] StoreAddrM = '0;
  logic [31:0] StoreDataM = '0;
  logic        LoadReqM = 1'b0;
  logic [31:0] LoadAddrM = '0;
  logic        MemAck = 1'b0;
  logic        StoreStall;
  logic        LoadHazard;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [3:0]  MemMask;
  logic [31:0] MemWData;
  logic        Empty;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .StoreMaskM(StoreMaskM), .StoreAddrM(StoreAddrM), .StoreDataM(StoreDataM),
    .LoadReqM(LoadReqM), .LoadAddrM(LoadAddrM), .MemAck(MemAck),
    .StoreStall(StoreStall), .LoadHazard(LoadHazard), .MemReq(MemReq),
    .MemAddr(MemAddr), .MemMask(MemMask), .MemWData(MemWData), .Empty(Empty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } memWriteT;

  memWriteT expQ[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  popped = 1'b0;
  bit  started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted writes, oldest first.
  always @(posedge CLK) begin
    if (!RESETn) begin
      expQ.delete();
    end else if (StoreMaskM != 4'b0000 && (expQ.size() + (popped ? 1 : 0)) < DEPTH) begin
      expQ.push_back('{addr: {StoreAddrM[31:2], 2'b00}, mask: StoreMaskM, data: StoreDataM});
    end
    popped = 1'b0;
  end

  // Monitor: compares the memory port against the queue head and pops on each handshake.
  always @(negedge CLK) begin
    if (started) begin
      bit hz;
      hz = 1'b0;
      foreach (expQ[i]) begin
        if (expQ[i].addr[31:2] == LoadAddrM[31:2]) hz = 1'b1;
      end
      check("StoreStall", 32'(StoreStall), 32'(StoreMaskM != 4'b0000 && expQ.size() == DEPTH));
      check("LoadHazard", 32'(LoadHazard), 32'(LoadReqM && hz));
      check("Empty", 32'(Empty), 32'(expQ.size() == 0));
      check("MemReq", 32'(MemReq), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        check("MemAddr", MemAddr, expQ[0].addr);
        check("MemMask", 32'(MemMask), 32'(expQ[0].mask));
        check("MemWData", MemWData, expQ[0].data);
        if (MemAck) begin
          void'(expQ.pop_front());
          popped = 1'b1;
        end
      end else begin
        check("MemMaskIdle", 32'(MemMask), 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    StoreAddrM = a;
    StoreMaskM = m;
    StoreDataM = d;
  endtask

  task automatic idle();
    StoreMaskM = 4'b0000;
  endtask

  task automatic drain();
    int n;
    idle();
    MemAck = 1'b1;
    n = 0;
    while (!Empty && n < 20) begin
      cyc();
      n++;
    end
    check("drainBound", 32'(Empty), 32'h1);
    MemAck = 1'b0;
  endtask

  initial begin
    logic [31:0] holdAddr;
    logic [31:0] holdData;
    logic [3:0]  holdMask;

    // Reset state
    RESETn = 1'b0;
    cyc();
    started = 1'b1;
    cyc();
    check("resetMemAddr", MemAddr, 32'h0);
    check("resetMemWData", MemWData, 32'h0);
    check("resetMemMask", 32'(MemMask), 32'h0);
    check("resetEmpty", 32'(Empty), 32'h1);
    RESETn = 1'b1;

    // Single store with ack tied high: request the next cycle, empty after that
    MemAck = 1'b1;
    offer(32'h1003, 4'b1000, 32'hAB000000);
    cyc();
    idle();
    check("t1MemReq", 32'(MemReq), 32'h1);
    check("t1MemAddr", MemAddr, 32'h1000);
    check("t1MemMask", 32'(MemMask), 32'b1000);
    check("t1MemWData", MemWData, 32'hAB000000);
    cyc();
    check("t1Empty", 32'(Empty), 32'h1);
    MemAck = 1'b0;

    // Fill to full, stall on the fifth, one ack frees a slot for the next cycle
    for (int i = 0; i < 4; i++) begin
      offer(32'h10 + 32'(4 * i), 4'b1111, 32'hC0DE0000 + 32'(i));
      cyc();
    end
    offer(32'h20, 4'b1111, 32'hC0DE0004);
    #1;
    check("t2Stall", 32'(StoreStall), 32'h1);
    MemAck = 1'b1;
    cyc();
    MemAck = 1'b0;
    #1;
    check("t2StallCleared", 32'(StoreStall), 32'h0);
    cyc();
    idle();
    check("t2HeadAfterAck", MemAddr, 32'h14);
    drain();

    // Outputs held stable while ack is withheld
    offer(32'h3000, 4'b0011, 32'h12345678);
    cyc();
    idle();
    holdAddr = MemAddr;
    holdMask = MemMask;
    holdData = MemWData;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t3HoldAddr", MemAddr, holdAddr);
      check("t3HoldMask", 32'(MemMask), 32'(holdMask));
      check("t3HoldData", MemWData, holdData);
      check("t3HoldReq", 32'(MemReq), 32'h1);
    end
    drain();

    // Word-granular load hazard
    offer(32'h2002, 4'b0100, 32'h00560000);
    cyc();
    idle();
    LoadReqM = 1'b1;
    LoadAddrM = 32'h2000;
    #1;
    check("t4HazardSameWord", 32'(LoadHazard), 32'h1);
    LoadAddrM = 32'h2004;
    #1;
    check("t4HazardOtherWord", 32'(LoadHazard), 32'h0);
    MemAck = 1'b1;
    cyc();
    MemAck = 1'b0;
    LoadAddrM = 32'h2000;
    #1;
    check("t4HazardAfterAck", 32'(LoadHazard), 32'h0);
    LoadReqM = 1'b0;

    // Reset with three entries pending and an unacked head
    for (int i = 0; i < 3; i++) begin
      offer(32'h4000 + 32'(4 * i), 4'b0001, 32'h11 * (i + 1));
      cyc();
    end
    idle();
    RESETn = 1'b0;
    cyc();
    RESETn = 1'b1;
    check("t5ReqAfterReset", 32'(MemReq), 32'h0);
    check("t5EmptyAfterReset", 32'(Empty), 32'h1);
    offer(32'h5004, 4'b1100, 32'hBEEF0000);
    cyc();
    idle();
    check("t5PostResetAddr", MemAddr, 32'h5004);
    drain();

    // Pointer wrap: 2*DEPTH+1 back-to-back enqueue/dequeue pairs
    MemAck = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      offer(32'h6000 + 32'(4 * i), 4'b1111, 32'hA5000000 + 32'(i));
      cyc();
    end
    drain();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        offer({26'h0, 4'($urandom_range(0, 7)), 2'($urandom)}, 4'($urandom), $urandom);
      end else begin
        idle();
      end
      LoadReqM  = 1'($urandom);
      LoadAddrM = {26'h0, 4'($urandom_range(0, 7)), 2'($urandom)};
      MemAck    = ($urandom_range(0, 2) != 0);
      RESETn    = ($urandom_range(0, 99) != 0);
      cyc();
    end
    RESETn = 1'b1;
    LoadReqM = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
